alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle PDP-8 accumulator/ALU; successor to the combinational add/and stage.
- Owns the AC and Link registers internally.
- Executes TAD-style add, AND, increment, load and rotates (single or double), with a start/busy/done handshake.
- Sits between the operand bus (MB data) and the CPU sequencer; the sequencer issues one op at a time and waits for done.

Parameters:
- WIDTH, 12, AC width in bits; must be even and >=4.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  3  operation code, latched with start
- dbl  in  1  rotate twice (RTL/RTR) when 1; latched with start; ignored for non-rotate ops
- b  in  WIDTH  operand; latched with start
- ci  in  1  carry-in for ADD / link value for LOAD; latched with start
- ac  out  WIDTH  accumulator register
- link  out  1  link register
- zero  out  1  ac == 0 (combinational from register)
- neg  out  1  ac[WIDTH-1]
- busy  out  1  high in EXEC
- done  out  1  single-cycle pulse in DONE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, ac=0, link=0, busy=0, done=0, latched operands=0, step counter=0. Reset mid-operation aborts it; no done pulse is produced.
- States:
  - IDLE: start=1 at edge k latches op/dbl/b/ci, loads step count, goes to EXEC.
  - EXEC: one step per edge; after the last step goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE. No queueing; the requester must re-assert.
- Step counts:
  - ADD/AND/IAC/LOAD/reserved: 1.
  - RAL/RAR: 1, or 2 if dbl.
  - BSW: WIDTH/2.
- Latency: start at edge k, single-step result visible after edge k+1, done high between k+1 and k+2. Multi-step ops add one cycle per extra step.
- ac/link change only on EXEC edges. They hold the previous result in IDLE/DONE.
- Op codes:
  - 000 ADD: sum = ac + b + ci (WIDTH+1 bits); ac <= sum[WIDTH-1:0]; link <= link ^ sum[WIDTH] (carry complements link, PDP-8 TAD semantics).
  - 001 AND: ac <= ac & b; link unchanged.
  - 010 RAL: per step, {link,ac} rotates left 1 (link <= ac[MSB], ac[0] <= old link).
  - 011 RAR: per step, {link,ac} rotates right 1.
  - 100 IAC: ac <= ac+1 mod 2^WIDTH; link complemented on carry out (ac was all ones).
  - 101 LOAD: ac <= b; link <= ci.
  - 110 BSW: see Optional Feature.
  - 111 reserved: no-op, 1 step; ac/link unchanged.
- Wrap-around: all arithmetic is modulo 2^WIDTH, and carry only affects link as stated. An AND result never touches link.
- zero/neg reflect the registers at all times, including during multi-step ops (intermediate values visible).

Optional Feature:
- Macro ALU_SEQ_BSW_EN.
- Defined: op 110 swaps the WIDTH/2-bit halves of ac. It is implemented as WIDTH/2 steps of ac-only left rotate by 1 (link excluded, unchanged); done after WIDTH/2 EXEC cycles.
- Not defined: op 110 behaves exactly as reserved 111 (1-step no-op, ac/link unchanged).

Test Plan:
- Reset then LOAD b=7777(oct) ci=0; ADD b=0001 ci=0 -> ac=0000, link=1, zero=1, done high exactly 2 cycles after start edge.
- LOAD b=4000 ci=0; RAL dbl=1 -> after first step ac=0000 link=1, final ac=0001 link=0; done 3 cycles after start, busy high 2 cycles.
- LOAD b=5252 ci=1; AND b=0707 -> ac=0202, link=1 (unchanged); then IAC on ac=7777 link=1 -> ac=0000 link=0.
- During a RAR dbl=1, assert start with op=LOAD b=1234 -> ignored; result is the rotate only, one done pulse.
- Start RAL dbl=1, pull reset_n low during first EXEC cycle -> ac=0, link=0, busy=0, done never pulses, state IDLE after release.
- ALU_SEQ_BSW_EN defined: LOAD b=0077 ci=1; BSW -> ac=7700, link=1, done 7 cycles after start (6 steps). Undefined: ac stays 0077, done after 2 cycles.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle PDP-8 accumulator/ALU: owns AC and Link and runs one op per start/done handshake.
// The BSW half-swap op is enabled by defining ALU_SEQ_BSW_EN; otherwise op 110 is a 1-step no-op.
//
//   state  | meaning
//   -------+--------------------------------------------------
//   S_IDLE | waiting for start; latches op/dbl/b/ci on start
//   S_EXEC | one step per clock until the step counter hits 1
//   S_DONE | done pulse for one cycle, then back to S_IDLE
module alu_seq #(
    parameter int WIDTH = 12
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic             dbl_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic [WIDTH-1:0] ac_o,
    output logic             link_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_RAL  = 3'b010;
    localparam logic [2:0] OP_RAR  = 3'b011;
    localparam logic [2:0] OP_IAC  = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b101;
`ifdef ALU_SEQ_BSW_EN
    localparam logic [2:0] OP_BSW  = 3'b110;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  ac_q, ac_d;
    logic              link_q, link_d;
    logic [2:0]        op_q, op_d;
    logic              dbl_q, dbl_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              ci_q, ci_d;
    logic [CW-1:0]     steps_q, steps_d;

    logic [CW-1:0]     steps_load;
    logic [WIDTH:0]    sum_add;
    logic [WIDTH:0]    sum_inc;

    always_comb begin
        steps_load = CW'(1);
        case (op_i)
            OP_RAL, OP_RAR: if (dbl_i) steps_load = CW'(2);
`ifdef ALU_SEQ_BSW_EN
            OP_BSW:         steps_load = CW'(WIDTH / 2);
`endif
            default: ;
        endcase
    end

    assign sum_add = {1'b0, ac_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, ci_q};
    assign sum_inc = {1'b0, ac_q} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        ac_d    = ac_q;
        link_d  = link_q;
        op_d    = op_q;
        dbl_d   = dbl_q;
        b_d     = b_q;
        ci_d    = ci_q;
        steps_d = steps_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d    = op_i;
                    dbl_d   = dbl_i;
                    b_d     = b_i;
                    ci_d    = ci_i;
                    steps_d = steps_load;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        ac_d   = sum_add[WIDTH-1:0];
                        link_d = link_q ^ sum_add[WIDTH];
                    end
                    OP_AND:  ac_d = ac_q & b_q;
                    OP_RAL:  {link_d, ac_d} = {ac_q, link_q};
                    OP_RAR:  {link_d, ac_d} = {ac_q[0], link_q, ac_q[WIDTH-1:1]};
                    OP_IAC: begin
                        ac_d   = sum_inc[WIDTH-1:0];
                        link_d = link_q ^ sum_inc[WIDTH];
                    end
                    OP_LOAD: begin
                        ac_d   = b_q;
                        link_d = ci_q;
                    end
`ifdef ALU_SEQ_BSW_EN
                    // Link stays out of the rotate, so WIDTH/2 steps swap the halves.
                    OP_BSW:  ac_d = {ac_q[WIDTH-2:0], ac_q[WIDTH-1]};
`endif
                    default: ;
                endcase
                if (steps_q == CW'(1)) begin
                    state_d = S_DONE;
                end else begin
                    steps_d = steps_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            ac_q    <= '0;
            link_q  <= 1'b0;
            op_q    <= '0;
            dbl_q   <= 1'b0;
            b_q     <= '0;
            ci_q    <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            ac_q    <= ac_d;
            link_q  <= link_d;
            op_q    <= op_d;
            dbl_q   <= dbl_d;
            b_q     <= b_d;
            ci_q    <= ci_d;
            steps_q <= steps_d;
        end
    end

    assign ac_o   = ac_q;
    assign link_o = link_q;
    assign zero_o = (ac_q == '0);
    assign neg_o  = ac_q[WIDTH-1];
    assign busy_o = (state_q == S_EXEC);
    assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus random ops against an arithmetic reference model.
// Honours ALU_SEQ_BSW_EN the same way the design does.
module tb_alu_seq;

    localparam int W   = 12;
    localparam int MOD = 1 << W;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          start_i;
    logic [2:0]    op_i;
    logic          dbl_i;
    logic [W-1:0]  b_i;
    logic          ci_i;
    logic [W-1:0]  ac_o;
    logic          link_o;
    logic          zero_o;
    logic          neg_o;
    logic          busy_o;
    logic          done_o;

    int n_pass  = 0;
    int n_total = 0;
    int m_ac    = 0;
    int m_link  = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .start_i   (start_i),
        .op_i      (op_i),
        .dbl_i     (dbl_i),
        .b_i       (b_i),
        .ci_i      (ci_i),
        .ac_o      (ac_o),
        .link_o    (link_o),
        .zero_o    (zero_o),
        .neg_o     (neg_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: whole-operation result, not step by step.
    task automatic model(input int op, input int dbl, input int b, input int ci, output int steps);
        int s, v, n;
        steps = 1;
        n = (dbl != 0) ? 2 : 1;
        v = m_link * MOD + m_ac;
        case (op)
            0: begin
                s = m_ac + b + ci;
                m_ac = s % MOD;
                if (s >= MOD) m_link = 1 - m_link;
            end
            1: m_ac = m_ac & b;
            2: begin
                v = ((v << n) | (v >> (W + 1 - n))) & (2 * MOD - 1);
                m_link = v / MOD;
                m_ac = v % MOD;
                steps = n;
            end
            3: begin
                v = ((v >> n) | (v << (W + 1 - n))) & (2 * MOD - 1);
                m_link = v / MOD;
                m_ac = v % MOD;
                steps = n;
            end
            4: begin
                s = m_ac + 1;
                if (s == MOD) m_link = 1 - m_link;
                m_ac = s % MOD;
            end
            5: begin
                m_ac = b;
                m_link = ci;
            end
`ifdef ALU_SEQ_BSW_EN
            6: begin
                m_ac = ((m_ac >> (W / 2)) | (m_ac << (W / 2))) % MOD;
                steps = W / 2;
            end
`endif
            default: ;
        endcase
    endtask

    // Issues one op, optionally hammering start with a LOAD while it runs,
    // and checks latency, busy length, single done pulse and the result.
    task automatic do_op(input string tag, input int op, input int dbl, input int b, input int ci,
                         input bit junk);
        int exp_steps, edges, busy_cnt;
        bit got;
        model(op, dbl, b, ci, exp_steps);
        op_i    = 3'(op);
        dbl_i   = 1'(dbl);
        b_i     = W'(b);
        ci_i    = 1'(ci);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = junk;
        if (junk) begin
            op_i = 3'b101;
            b_i  = W'(12'o1234);
            ci_i = 1'b1;
        end
        edges = 0;
        busy_cnt = 32'(busy_o);
        got = 1'b0;
        while (!got && edges < 64) begin
            @(posedge clk_i); #1;
            edges++;
            if (done_o) got = 1'b1;
            else busy_cnt += 32'(busy_o);
        end
        start_i = 1'b0;
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, edges, exp_steps);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_steps);
        chk({tag, "_ac"}, 32'(ac_o), m_ac);
        chk({tag, "_link"}, 32'(link_o), m_link);
        chk({tag, "_zero"}, 32'(zero_o), 32'(m_ac == 0));
        chk({tag, "_neg"}, 32'(neg_o), 32'(m_ac >= MOD / 2));
        @(posedge clk_i); #1;
        chk({tag, "_done_drop"}, {30'd0, done_o, busy_o}, 32'd0);
    endtask

    initial begin
        int steps_unused, hits;
        reset_n_i = 1'b0;
        start_i   = 1'b0;
        op_i      = 3'b000;
        dbl_i     = 1'b0;
        b_i       = '0;
        ci_i      = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ac", 32'(ac_o), 0);
        chk("rst_link", 32'(link_o), 0);
        chk("rst_flags", {28'd0, zero_o, neg_o, busy_o, done_o}, 32'b1000);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;

        // LOAD 7777 then ADD 1: carry complements link.
        do_op("t1_load", 5, 0, 12'o7777, 0, 1'b0);
        do_op("t1_add", 0, 0, 12'o0001, 0, 1'b0);
        chk("t1_ac_lit", 32'(ac_o), 0);
        chk("t1_link_lit", 32'(link_o), 1);

        // LOAD 4000, RAL double.
        do_op("t2_load", 5, 0, 12'o4000, 0, 1'b0);
        do_op("t2_ral2", 2, 1, 0, 0, 1'b0);
        chk("t2_ac_lit", 32'(ac_o), 1);

        // AND leaves link alone; IAC on all ones wraps and complements link.
        do_op("t3_load", 5, 0, 12'o5252, 1, 1'b0);
        do_op("t3_and", 1, 0, 12'o0707, 0, 1'b0);
        chk("t3_and_lit", {19'd0, link_o, ac_o}, {20'd1, 12'o0202});
        do_op("t3_load2", 5, 0, 12'o7777, 1, 1'b0);
        do_op("t3_iac", 4, 0, 0, 0, 1'b0);
        chk("t3_iac_lit", {19'd0, link_o, ac_o}, 32'd0);

        // start during a RAR double is ignored.
        do_op("t4_load", 5, 0, 12'o0003, 0, 1'b0);
        do_op("t4_rar2_junk", 3, 1, 0, 0, 1'b1);

        // Reset in the first EXEC cycle aborts with no done pulse.
        op_i = 3'b010; dbl_i = 1'b1; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        reset_n_i = 1'b0;
        #1;
        chk("t5_rst_ac", 32'(ac_o), 0);
        chk("t5_rst_lbd", {29'd0, link_o, busy_o, done_o}, 0);
        #1;
        reset_n_i = 1'b1;
        m_ac = 0;
        m_link = 0;
        hits = 0;
        repeat (5) begin
            @(posedge clk_i); #1;
            hits += 32'(done_o) + 32'(busy_o);
        end
        chk("t5_no_done", hits, 0);

        // BSW: half swap when enabled, otherwise a 1-step no-op.
        do_op("t6_load", 5, 0, 12'o0077, 1, 1'b0);
        do_op("t6_bsw", 6, 0, 0, 0, 1'b0);
`ifdef ALU_SEQ_BSW_EN
        chk("t6_bsw_lit", {19'd0, link_o, ac_o}, {20'd1, 12'o7700});
`else
        chk("t6_bsw_lit", {19'd0, link_o, ac_o}, {20'd1, 12'o0077});
`endif
        do_op("t6_rsvd", 7, 1, 12'o1111, 1, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int op, b;
            op = int'($urandom_range(0, 7));
            b  = ($urandom_range(0, 3) == 0) ? MOD - 1 : int'($urandom_range(0, MOD - 1));
            do_op("rnd", op, int'($urandom_range(0, 1)), b, int'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)));
        end
        steps_unused = 0;
        chk("final_idle", {30'd0, busy_o, done_o}, steps_unused);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
